mesm6_memctl: RTL and testbench

MESM6_MEMCTL -- requirements
Module: mesm6_memctl

---
 rtl/mesm6_memctl.sv | 116 +++++++++++
 tb/tb_mesm6_memctl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_memctl.sv
// Arbitrates the MESM-6 instruction and data buses onto one single-ported SRAM.
// Each access is one registered strobe followed by WAIT+1 wait cycles before the read data is captured.
module mesm6_memctl #(
   parameter int WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ibus_fetch,
   input  logic [14:0] ibus_addr,
   output logic [47:0] ibus_input,
   output logic        ibus_done,
   input  logic        dbus_read,
   input  logic        dbus_write,
   input  logic [14:0] dbus_addr,
   input  logic [47:0] dbus_output,
   output logic [47:0] dbus_input,
   output logic        dbus_done,
   output logic        mem_en,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [47:0] mem_wdata,
   input  logic [47:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

   localparam logic [3:0] LAST = 4'(WAIT + 1);

   state_t     state;
   logic [3:0] cnt;
   logic       served_d;
   logic       served_i;
   logic       op_write;
   logic       op_zero;

   // Single FSM; strobes and done flags default low so every pulse lasts one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         served_d   <= 1'b0;
         served_i   <= 1'b0;
         op_write   <= 1'b0;
         op_zero    <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ibus_input <= '0;
         dbus_input <= '0;
         ibus_done  <= 1'b0;
         dbus_done  <= 1'b0;
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         ibus_done <= 1'b0;
         dbus_done <= 1'b0;
         case (state)
            IDLE: begin
               cnt      <= '0;
               served_d <= 1'b0;
               served_i <= 1'b0;
               if (dbus_read || dbus_write) begin
                  // Address 0 is a hardwired zero word: the SRAM is never strobed for it.
                  state    <= DACC;
                  served_d <= 1'b1;
                  op_write <= dbus_write;
                  op_zero  <= (dbus_addr == 15'd0);
                  mem_en   <= (dbus_addr != 15'd0);
                  mem_we   <= dbus_write && (dbus_addr != 15'd0);
                  mem_addr <= dbus_addr;
                  if (dbus_write) mem_wdata <= dbus_output;
               end else if (ibus_fetch) begin
                  state    <= IACC;
                  served_i <= 1'b1;
                  mem_en   <= 1'b1;
                  mem_addr <= ibus_addr;
               end
            end
            DACC: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (!op_write) dbus_input <= op_zero ? 48'd0 : mem_rdata;
                  if (ibus_fetch) begin
                     state    <= IACC;
                     served_i <= 1'b1;
                     mem_en   <= 1'b1;
                     mem_addr <= ibus_addr;
                  end else begin
                     state     <= DONE;
                     dbus_done <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            IACC: begin
               if (cnt == LAST) begin
                  cnt        <= '0;
                  ibus_input <= mem_rdata;
                  state      <= DONE;
                  ibus_done  <= served_i;
                  dbus_done  <= served_d;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mesm6_memctl.sv
// Bench for mesm6_memctl: three instances with WAIT = 0, 1 and 2, each on its own SRAM model.
// Expected transaction results are queued when a request is driven and checked when done arrives.
module tb_mesm6_memctl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        ibus_fetch [3];
   logic        dbus_read [3];
   logic        dbus_write [3];
   logic [14:0] ibus_addr [3];
   logic [14:0] dbus_addr [3];
   logic [47:0] dbus_output [3];
   logic [47:0] ibus_input [3];
   logic [47:0] dbus_input [3];
   logic        ibus_done [3];
   logic        dbus_done [3];
   logic        mem_en [3];
   logic        mem_we [3];
   logic [14:0] mem_addr [3];
   logic [47:0] mem_wdata [3];
   logic [47:0] mem_rdata [3];
   int          en_cnt [3];
   int          we_cnt [3];
   int          en_cyc [3];
   logic [14:0] en_addr [3];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          done_at;
      logic        ib_done;
      logic        db_done;
      logic [47:0] ib_data;
      logic [47:0] db_data;
   } exp_t;
   exp_t sb[$];

   int          o_cyc;
   logic        o_idn;
   logic        o_ddn;
   logic [47:0] o_id;
   logic [47:0] o_dd;

   // Contents of SRAM words that have never been written
   function automatic logic [47:0] init_word(input logic [14:0] a);
      if (a == 15'd0) return 48'h5;
      if (a == 15'o100) return 48'h123456789ABC;
      return {1'b1, a, 1'b0, ~a, 1'b1, a};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [47:0] sram [0:32767];
      bit          written [0:32767];
      logic [47:0] pipe [0:g];
      int          ens = 0;
      int          wes = 0;
      int          ecyc = -1;
      logic [14:0] eaddr = '0;

      mesm6_memctl #(.WAIT(g)) dut (
         .clk        (clk),
         .reset      (reset),
         .ibus_fetch (ibus_fetch[g]),
         .ibus_addr  (ibus_addr[g]),
         .ibus_input (ibus_input[g]),
         .ibus_done  (ibus_done[g]),
         .dbus_read  (dbus_read[g]),
         .dbus_write (dbus_write[g]),
         .dbus_addr  (dbus_addr[g]),
         .dbus_output(dbus_output[g]),
         .dbus_input (dbus_input[g]),
         .dbus_done  (dbus_done[g]),
         .mem_en     (mem_en[g]),
         .mem_we     (mem_we[g]),
         .mem_addr   (mem_addr[g]),
         .mem_wdata  (mem_wdata[g]),
         .mem_rdata  (mem_rdata[g])
      );

      // Read data is valid only in cycle E+1+WAIT; every other cycle carries a poison word
      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g]) begin
            sram[mem_addr[g]]    <= mem_wdata[g];
            written[mem_addr[g]] <= 1'b1;
            wes <= wes + 1;
         end
         pipe[0] <= (mem_en[g] && !mem_we[g])
                    ? (written[mem_addr[g]] ? sram[mem_addr[g]] : init_word(mem_addr[g]))
                    : 48'hBAD0BAD0BAD0;
         for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
         if (mem_en[g]) begin
            ens   <= ens + 1;
            ecyc  <= cyc;
            eaddr <= mem_addr[g];
         end
      end

      assign mem_rdata[g] = pipe[g];
      assign en_cnt[g]    = ens;
      assign we_cnt[g]    = wes;
      assign en_cyc[g]    = ecyc;
      assign en_addr[g]   = eaddr;
   end

   task automatic drive(input int i, input logic f, input logic rd, input logic wr,
                        input logic [14:0] ia, input logic [14:0] da, input logic [47:0] wd,
                        output int n);
      @(posedge clk); #1;
      ibus_fetch[i] = f;  dbus_read[i] = rd; dbus_write[i] = wr;
      ibus_addr[i]  = ia; dbus_addr[i] = da; dbus_output[i] = wd;
      n = cyc;
   endtask

   // Waits (bounded) for a done pulse; a timeout leaves o_cyc at -1
   task automatic await_done(input int i);
      o_cyc = -1; o_idn = 1'b0; o_ddn = 1'b0; o_id = '0; o_dd = '0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (ibus_done[i] === 1'b1 || dbus_done[i] === 1'b1) begin
            o_cyc = cyc; o_idn = ibus_done[i]; o_ddn = dbus_done[i];
            o_id = ibus_input[i]; o_dd = dbus_input[i];
            break;
         end
      end
      ibus_fetch[i] = 1'b0; dbus_read[i] = 1'b0; dbus_write[i] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ibus_fetch[i] = 0; dbus_read[i] = 0; dbus_write[i] = 0;
         ibus_addr[i] = 0; dbus_addr[i] = 0; dbus_output[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({mem_en[i], mem_we[i], ibus_done[i], dbus_done[i], mem_addr[i], mem_wdata[i],
              ibus_input[i], dbus_input[i]} !== 163'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_state inst %0d got en=%b we=%b idn=%b ddn=%b addr=%h wd=%h ii=%h di=%h want all zero",
                     i, mem_en[i], mem_we[i], ibus_done[i], dbus_done[i], mem_addr[i], mem_wdata[i],
                     ibus_input[i], dbus_input[i]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      int n, en0;
      exp_t e;
      en0 = en_cnt[0];
      drive(0, 1, 0, 0, 15'o100, 15'd0, 48'd0, n);
      sb.push_back('{n + 3, 1'b1, 1'b0, 48'h123456789ABC, 48'd0});
      await_done(0);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL fetch_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if (o_idn !== e.ib_done) begin n_bad++; $display("[TB] FAIL fetch_ibus_done got %b want %b", o_idn, e.ib_done); end
      n_cmp++; if (o_ddn !== e.db_done) begin n_bad++; $display("[TB] FAIL fetch_dbus_done got %b want %b", o_ddn, e.db_done); end
      n_cmp++; if (o_id !== e.ib_data) begin n_bad++; $display("[TB] FAIL fetch_data got %h want %h", o_id, e.ib_data); end
      n_cmp++; if (en_cyc[0] !== n + 1) begin n_bad++; $display("[TB] FAIL fetch_en_cycle got %0d want %0d", en_cyc[0], n + 1); end
      n_cmp++; if (en_cnt[0] - en0 !== 1) begin n_bad++; $display("[TB] FAIL fetch_en_count got %0d want 1", en_cnt[0] - en0); end
   endtask

   task automatic test_write_read();
      int n, en0, we0;
      exp_t e;
      en0 = en_cnt[2]; we0 = we_cnt[2];
      drive(2, 0, 0, 1, 15'd0, 15'd5, 48'hFFFF00000001, n);
      sb.push_back('{n + 5, 1'b0, 1'b1, 48'd0, 48'd0});
      await_done(2);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL write_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if ({o_idn, o_ddn} !== {e.ib_done, e.db_done}) begin n_bad++; $display("[TB] FAIL write_dones got %b%b want %b%b", o_idn, o_ddn, e.ib_done, e.db_done); end
      n_cmp++; if (en_cnt[2] - en0 !== 1 || we_cnt[2] - we0 !== 1) begin n_bad++; $display("[TB] FAIL write_strobes got en=%0d we=%0d want 1/1", en_cnt[2] - en0, we_cnt[2] - we0); end
      n_cmp++; if (en_addr[2] !== 15'd5) begin n_bad++; $display("[TB] FAIL write_addr got %h want 5", en_addr[2]); end
      drive(2, 0, 1, 0, 15'd0, 15'd5, 48'd0, n);
      sb.push_back('{n + 5, 1'b0, 1'b1, 48'd0, 48'hFFFF00000001});
      await_done(2);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL readback_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL readback_data got %h want %h", o_dd, e.db_data); end
   endtask

   task automatic test_both_ports();
      int n, en0;
      exp_t e;
      en0 = en_cnt[1];
      drive(1, 1, 1, 0, 15'd200, 15'd300, 48'd0, n);
      sb.push_back('{n + 7, 1'b1, 1'b1, init_word(15'd200), init_word(15'd300)});
      await_done(1);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL both_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if ({o_idn, o_ddn} !== 2'b11) begin n_bad++; $display("[TB] FAIL both_dones got %b%b want 11", o_idn, o_ddn); end
      n_cmp++; if (o_id !== e.ib_data) begin n_bad++; $display("[TB] FAIL both_ibus_data got %h want %h", o_id, e.ib_data); end
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL both_dbus_data got %h want %h", o_dd, e.db_data); end
      n_cmp++; if (en_cnt[1] - en0 !== 2) begin n_bad++; $display("[TB] FAIL both_en_count got %0d want 2", en_cnt[1] - en0); end
   endtask

   task automatic test_zero_addr();
      int n, en0, we0;
      exp_t e;
      drive(0, 0, 1, 0, 15'd0, 15'd7, 48'd0, n);
      sb.push_back('{n + 3, 1'b0, 1'b1, 48'h123456789ABC, init_word(15'd7)});
      await_done(0);
      e = sb.pop_front();
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL read7_data got %h want %h", o_dd, e.db_data); end
      en0 = en_cnt[0];
      drive(0, 0, 1, 0, 15'd0, 15'd0, 48'd0, n);
      sb.push_back('{n + 3, 1'b0, 1'b1, 48'h123456789ABC, 48'd0});
      await_done(0);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL read0_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL read0_data got %h want %h", o_dd, e.db_data); end
      n_cmp++; if (en_cnt[0] - en0 !== 0) begin n_bad++; $display("[TB] FAIL read0_en_count got %0d want 0", en_cnt[0] - en0); end
      en0 = en_cnt[0]; we0 = we_cnt[0];
      drive(0, 0, 0, 1, 15'd0, 15'd0, 48'h000000001234, n);
      sb.push_back('{n + 3, 1'b0, 1'b1, 48'h123456789ABC, 48'd0});
      await_done(0);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL write0_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if (en_cnt[0] - en0 !== 0 || we_cnt[0] - we0 !== 0) begin n_bad++; $display("[TB] FAIL write0_strobes got en=%0d we=%0d want 0/0", en_cnt[0] - en0, we_cnt[0] - we0); end
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL write0_hold got %h want %h", o_dd, e.db_data); end
   endtask

   task automatic test_read_write_both();
      int n, we0;
      exp_t e;
      we0 = we_cnt[0];
      drive(0, 0, 1, 1, 15'd0, 15'd9, 48'hCAFE0000BEEF, n);
      sb.push_back('{n + 3, 1'b0, 1'b1, 48'h123456789ABC, 48'd0});
      await_done(0);
      e = sb.pop_front();
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL rw_hold got %h want %h", o_dd, e.db_data); end
      n_cmp++; if (we_cnt[0] - we0 !== 1) begin n_bad++; $display("[TB] FAIL rw_we_count got %0d want 1", we_cnt[0] - we0); end
      drive(0, 0, 1, 0, 15'd0, 15'd9, 48'd0, n);
      sb.push_back('{n + 3, 1'b0, 1'b1, 48'h123456789ABC, 48'hCAFE0000BEEF});
      await_done(0);
      e = sb.pop_front();
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL rw_readback got %h want %h", o_dd, e.db_data); end
   endtask

   task automatic test_drop_latch();
      int n;
      exp_t e;
      drive(1, 0, 1, 0, 15'd0, 15'd20, 48'd0, n);
      sb.push_back('{n + 4, 1'b0, 1'b1, init_word(15'd200), init_word(15'd20)});
      @(posedge clk); #1;
      dbus_read[1] = 1'b0;
      dbus_addr[1] = 15'd21;
      await_done(1);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL drop_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if (o_ddn !== e.db_done) begin n_bad++; $display("[TB] FAIL drop_dbus_done got %b want %b", o_ddn, e.db_done); end
      n_cmp++; if (o_dd !== e.db_data) begin n_bad++; $display("[TB] FAIL drop_latched_data got %h want %h", o_dd, e.db_data); end
   endtask

   task automatic test_reset_mid();
      int n, we0;
      exp_t e;
      we0 = we_cnt[2];
      drive(2, 0, 0, 1, 15'd0, 15'd11, 48'h000000001111, n);
      @(posedge clk); #1;
      n_cmp++; if ({mem_en[2], mem_we[2]} !== 2'b11) begin n_bad++; $display("[TB] FAIL midreset_strobe got %b%b want 11", mem_en[2], mem_we[2]); end
      reset = 1'b1;
      dbus_write[2] = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_en[2], mem_we[2], ibus_done[2], dbus_done[2], mem_addr[2], mem_wdata[2],
           ibus_input[2], dbus_input[2]} !== 163'd0) begin
         n_bad++;
         $display("[TB] FAIL midreset_state got en=%b we=%b addr=%h wd=%h di=%h want all zero",
                  mem_en[2], mem_we[2], mem_addr[2], mem_wdata[2], dbus_input[2]);
      end
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++; if (we_cnt[2] - we0 !== 1) begin n_bad++; $display("[TB] FAIL midreset_we_count got %0d want 1", we_cnt[2] - we0); end
      drive(2, 1, 0, 0, 15'o100, 15'd0, 48'd0, n);
      sb.push_back('{n + 5, 1'b1, 1'b0, 48'h123456789ABC, 48'd0});
      await_done(2);
      e = sb.pop_front();
      n_cmp++; if (o_cyc !== e.done_at) begin n_bad++; $display("[TB] FAIL postreset_done_cycle got %0d want %0d", o_cyc, e.done_at); end
      n_cmp++; if (o_id !== e.ib_data) begin n_bad++; $display("[TB] FAIL postreset_data got %h want %h", o_id, e.ib_data); end
   endtask

   task automatic test_back_to_back();
      int n, en0, d1, d2;
      exp_t e;
      en0 = en_cnt[0];
      d1 = -1; d2 = -1;
      drive(0, 1, 0, 0, 15'o100, 15'd0, 48'd0, n);
      sb.push_back('{n + 3, 1'b1, 1'b0, 48'h123456789ABC, 48'd0});
      sb.push_back('{n + 7, 1'b1, 1'b0, 48'h123456789ABC, 48'd0});
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (ibus_done[0] === 1'b1) begin
            if (d1 < 0) d1 = cyc;
            else begin
               d2 = cyc;
               ibus_fetch[0] = 1'b0;
               break;
            end
         end
      end
      ibus_fetch[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++; if (d1 !== e.done_at) begin n_bad++; $display("[TB] FAIL b2b_first_done got %0d want %0d", d1, e.done_at); end
      e = sb.pop_front();
      n_cmp++; if (d2 !== e.done_at) begin n_bad++; $display("[TB] FAIL b2b_second_done got %0d want %0d", d2, e.done_at); end
      n_cmp++; if (en_cnt[0] - en0 !== 2) begin n_bad++; $display("[TB] FAIL b2b_en_count got %0d want 2", en_cnt[0] - en0); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_write_read();
      test_both_ports();
      test_zero_addr();
      test_read_write_both();
      test_drop_latch();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
